data_memory_bank: RTL

Parametrised single-port data memory for the multicycle CPU datapath. It accepts one read or write request per cycle over a valid/ready handshake and returns a registered response one cycle later. After reset it sweeps every word through an initialisation sequencer, writing zeros or the compiled-in preload image, and holds off requests until that sweep completes. It sits between the CPU memory-stage controller and storage, and replaces the fixed 256×8 combinational-read memory.

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_array.sv | 28 ++
 rtl/data_memory_bank.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and DMEM_PRELOAD_EN image for data_memory_bank
package dmem_pkg;

    typedef enum logic {
        INIT,
        READY
    } dmem_state_e;

    // Selects which register drives rsp_rdata so the output holds across idle cycles.
    typedef enum logic [1:0] {
        RSP_ZERO,
        RSP_READ,
        RSP_WRITE
    } dmem_rsp_src_e;

    localparam int unsigned PRELOAD_LO = 100;
    localparam int unsigned PRELOAD_HI = 120;
    localparam int unsigned IMG_W      = 8;

    function automatic logic [IMG_W-1:0] dmem_preload(input int unsigned addr);
        logic [IMG_W-1:0] val;
        val = '0;
        if (addr >= PRELOAD_LO && addr <= PRELOAD_HI) begin
            case (addr)
                100:     val = 8'h83;
                101:     val = 8'h14;
                102:     val = 8'hA0;
                103:     val = 8'hE4;
                106:     val = 8'h15;
                107:     val = 8'h14;
                108:     val = 8'h1D;
                109:     val = 8'h11;
                110:     val = 8'h14;
                111:     val = 8'h35;
                112:     val = 8'hF5;
                113:     val = 8'h1F;
                114:     val = 8'h34;
                115:     val = 8'h55;
                116:     val = 8'h75;
                117:     val = 8'h7F;
                118:     val = 8'h17;
                119:     val = 8'hE0;
                120:     val = 8'hFF;
                default: val = '0;
            endcase
        end
        return val;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DATA_W x DEPTH storage with one synchronous write port and one registered read port
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Callers never assert we and re for the same request, so read-during-write ordering is moot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - single-port data memory with init sweep and registered responses; DMEM_PRELOAD_EN selects the preload image
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    dmem_state_e       state;
    dmem_state_e       state_nxt;
    logic [IDX_W-1:0]  init_cnt;
    logic [IDX_W-1:0]  init_cnt_nxt;
    logic [DATA_W-1:0] init_wdata;

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;

    logic              arr_we;
    logic [IDX_W-1:0]  arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    dmem_rsp_src_e     rsp_src;
    logic [DATA_W-1:0] echo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == LAST_IDX) begin
                    state_nxt    = READY;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + IDX_W'(1);
                end
            end
            READY: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nxt = INIT;
        endcase
    end

`ifdef DMEM_PRELOAD_EN
    logic [IMG_W-1:0] preload_byte;
    assign preload_byte = dmem_preload(32'(init_cnt));
    assign init_wdata   = DATA_W'(preload_byte);
`else
    assign init_wdata   = '0;
`endif

    // Extra top bit lets DEPTH == 2**ADDR_W compare without overflow.
    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign req_idx  = req_addr[IDX_W-1:0];
    assign accept   = req_valid && req_ready;

    // Gating with rst drops any request that coincides with a reset edge.
    assign arr_we    = rst && ((state == INIT) || (accept && req_we && in_range));
    assign arr_waddr = (state == INIT) ? init_cnt : req_idx;
    assign arr_wdata = (state == INIT) ? init_wdata : req_wdata;
    assign arr_re    = rst && accept && !req_we && in_range;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (req_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_src   <= RSP_ZERO;
            echo_q    <= '0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err <= !in_range;
                echo_q  <= req_wdata;
                if (req_we) begin
                    rsp_src <= RSP_WRITE;
                end else if (in_range) begin
                    rsp_src <= RSP_READ;
                end else begin
                    rsp_src <= RSP_ZERO;
                end
            end
        end
    end

    always_comb begin
        rsp_rdata = '0;
        case (rsp_src)
            RSP_READ:  rsp_rdata = arr_rdata;
            RSP_WRITE: rsp_rdata = echo_q;
            default:   rsp_rdata = '0;
        endcase
    end

endmodule
